// File: rtl/fme_contador_fases.sv
// fme_contador_fases: phase-tracking counter that runs in lockstep with the
// interpolation controller. It walks OCIOSO -> ESCRITA -> FASE1 -> GAP2 ->
// FASE2P3 -> FASE3 -> GAP_POS -> POS3 -> OCIOSO and flags the last cycle of
// every counted phase.
// Optional feature: define FME_CONTADOR_ERRO_EN to add the sticky
// erro_sequencia output (enable seen while the tracker is busy).
module fme_contador_fases #(
  parameter int N_ESCRITA = 8,
  parameter int N_FASE1   = 8,
  parameter int N_FASE2P3 = 7,
  parameter int N_FASE3   = 9,
  parameter int N_POS     = 7,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 abortar,
  output logic                 escrita_finalizada,
  output logic                 fase1_finalizada,
  output logic                 fase2p3_finalizada,
  output logic                 fase3_finalizada,
  output logic                 pos_interpolacao_finalizada,
  output logic [CNT_WIDTH-1:0] contador,
  output logic                 ocupado
`ifdef FME_CONTADOR_ERRO_EN
  ,
  output logic                 erro_sequencia
`endif
);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] ESCRITA = 3'd1;
  localparam logic [2:0] FASE1   = 3'd2;
  localparam logic [2:0] GAP2    = 3'd3;
  localparam logic [2:0] FASE2P3 = 3'd4;
  localparam logic [2:0] FASE3   = 3'd5;
  localparam logic [2:0] GAP_POS = 3'd6;
  localparam logic [2:0] POS3    = 3'd7;

  // Terminal counter values: a phase of N cycles ends when contador reaches N-1.
  localparam logic [CNT_WIDTH-1:0] ULT_ESCRITA = CNT_WIDTH'(N_ESCRITA - 1);
  localparam logic [CNT_WIDTH-1:0] ULT_FASE1   = CNT_WIDTH'(N_FASE1 - 1);
  localparam logic [CNT_WIDTH-1:0] ULT_FASE2P3 = CNT_WIDTH'(N_FASE2P3 - 1);
  localparam logic [CNT_WIDTH-1:0] ULT_FASE3   = CNT_WIDTH'(N_FASE3 - 1);
  localparam logic [CNT_WIDTH-1:0] ULT_POS     = CNT_WIDTH'(N_POS - 1);
  // Both gaps last exactly two cycles.
  localparam logic [CNT_WIDTH-1:0] ULT_GAP     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_UM      = CNT_WIDTH'(1);

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  logic esc_fim_s;
  logic f1_fim_s;
  logic f2p3_fim_s;
  logic f3_fim_s;
  logic pos_fim_s;
  logic gap_fim_s;
  logic fim_s;
  logic ocupado_s;

  // Decode last-cycle flags purely from registered state and counter.
  always_comb begin
    esc_fim_s  = (state_q == ESCRITA) && (cnt_q == ULT_ESCRITA);
    f1_fim_s   = (state_q == FASE1)   && (cnt_q == ULT_FASE1);
    f2p3_fim_s = (state_q == FASE2P3) && (cnt_q == ULT_FASE2P3);
    f3_fim_s   = (state_q == FASE3)   && (cnt_q == ULT_FASE3);
    pos_fim_s  = (state_q == POS3)    && (cnt_q == ULT_POS);
    gap_fim_s  = ((state_q == GAP2) || (state_q == GAP_POS)) && (cnt_q == ULT_GAP);
    fim_s      = esc_fim_s | f1_fim_s | f2p3_fim_s | f3_fim_s | pos_fim_s | gap_fim_s;
    ocupado_s  = (state_q != OCIOSO);
  end

  assign escrita_finalizada          = esc_fim_s;
  assign fase1_finalizada            = f1_fim_s;
  assign fase2p3_finalizada          = f2p3_fim_s;
  assign fase3_finalizada            = f3_fim_s;
  assign pos_interpolacao_finalizada = pos_fim_s;
  assign contador                    = cnt_q;
  assign ocupado                     = ocupado_s;

  // Next state and counter: abort wins, each state advances on its last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abortar) begin
      state_d = OCIOSO;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (enable) begin
            state_d = ESCRITA;
          end else begin
            state_d = OCIOSO;
          end
        end
        ESCRITA: state_d = fim_s ? FASE1   : ESCRITA;
        FASE1:   state_d = fim_s ? GAP2    : FASE1;
        GAP2:    state_d = fim_s ? FASE2P3 : GAP2;
        FASE2P3: state_d = fim_s ? FASE3   : FASE2P3;
        FASE3:   state_d = fim_s ? GAP_POS : FASE3;
        GAP_POS: state_d = fim_s ? POS3    : GAP_POS;
        POS3:    state_d = fim_s ? OCIOSO  : POS3;
        default: state_d = OCIOSO;
      endcase
      // Counter restarts on every state change and never runs while idle.
      if ((state_q == OCIOSO) || fim_s) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_UM;
      end
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FME_CONTADOR_ERRO_EN
  logic erro_q;

  // Sticky flag: an enable arriving while busy is a sequencing error.
  always_ff @(posedge clock) begin
    if (reset) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= erro_q | (enable & ocupado_s);
    end
  end

  assign erro_sequencia = erro_q;
`endif

endmodule

// File: tb/tb_fme_contador_fases.sv
// Self-checking bench for fme_contador_fases: a position-in-run model (run
// laid out as a list of segment lengths) is compared every cycle against two
// instances (default parameters and N_FASE3=1), plus hand-computed timing pins.
module tb_fme_contador_fases;

  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset, enable, abortar;

  logic a_esc, a_f1, a_f2p3, a_f3, a_pos, a_ocup;
  logic [CW-1:0] a_cnt;
  logic b_esc, b_f1, b_f2p3, b_f3, b_pos, b_ocup;
  logic [CW-1:0] b_cnt;
`ifdef FME_CONTADOR_ERRO_EN
  logic a_erro, b_erro;
`endif

  fme_contador_fases #(.CNT_WIDTH(CW)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .abortar(abortar),
    .escrita_finalizada(a_esc), .fase1_finalizada(a_f1),
    .fase2p3_finalizada(a_f2p3), .fase3_finalizada(a_f3),
    .pos_interpolacao_finalizada(a_pos), .contador(a_cnt), .ocupado(a_ocup)
`ifdef FME_CONTADOR_ERRO_EN
    , .erro_sequencia(a_erro)
`endif
  );

  fme_contador_fases #(.N_FASE3(1), .CNT_WIDTH(CW)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .abortar(abortar),
    .escrita_finalizada(b_esc), .fase1_finalizada(b_f1),
    .fase2p3_finalizada(b_f2p3), .fase3_finalizada(b_f3),
    .pos_interpolacao_finalizada(b_pos), .contador(b_cnt), .ocupado(b_ocup)
`ifdef FME_CONTADOR_ERRO_EN
    , .erro_sequencia(b_erro)
`endif
  );

  always #5 clock = ~clock;

  // Model: a run is a sequence of segments; fin_id -1 marks an uncounted gap.
  int dur [2][7];
  int fin_id [7] = '{0, 1, -1, 2, 3, -1, 4};
  bit m_busy [2];
  int m_pos  [2];
  bit m_err  [2];

  int  n_vec = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;
  int  cyc;

  function automatic int total(input int m);
    int t = 0;
    for (int s = 0; s < 7; s++) t += dur[m][s];
    return t;
  endfunction

  // Expected {ocupado, fin[4:0], contador} for model m.
  function automatic logic [5+CW:0] expected(input int m);
    logic [4:0] fin = 5'b00000;
    int cnt = 0;
    int start = 0;
    if (m_busy[m]) begin
      for (int s = 0; s < 7; s++) begin
        if (m_pos[m] < start + dur[m][s]) begin
          cnt = m_pos[m] - start;
          if (fin_id[s] >= 0 && m_pos[m] == start + dur[m][s] - 1) fin[fin_id[s]] = 1'b1;
          break;
        end
        start += dur[m][s];
      end
    end
    return {m_busy[m], fin, CW'(cnt)};
  endfunction

  task automatic model_edge(input int m, input logic en, input logic ab, input logic rs);
    if (rs) begin
      m_busy[m] = 1'b0; m_pos[m] = 0; m_err[m] = 1'b0;
    end else begin
      if (en && m_busy[m]) m_err[m] = 1'b1;
      if (ab) begin
        m_busy[m] = 1'b0; m_pos[m] = 0;
      end else if (m_busy[m]) begin
        m_pos[m]++;
        if (m_pos[m] == total(m)) begin m_busy[m] = 1'b0; m_pos[m] = 0; end
      end else if (en) begin
        m_busy[m] = 1'b1; m_pos[m] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp_v, cyc, $time);
    end
  endtask

  // Apply one input vector, clock it, advance the model, return at negedge.
  task automatic step(input logic en, input logic ab, input logic rs);
    enable = en; abortar = ab; reset = rs;
    @(posedge clock);
    model_edge(0, en, ab, rs);
    model_edge(1, en, ab, rs);
    @(negedge clock);
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("dut_a_outputs", int'({a_ocup, a_pos, a_f3, a_f2p3, a_f1, a_esc, a_cnt}), int'(expected(0)));
      chk("dut_b_outputs", int'({b_ocup, b_pos, b_f3, b_f2p3, b_f1, b_esc, b_cnt}), int'(expected(1)));
      chk("dut_a_onehot_fin", int'($countones({a_pos, a_f3, a_f2p3, a_f1, a_esc}) <= 1), 1);
      chk("dut_b_onehot_fin", int'($countones({b_pos, b_f3, b_f2p3, b_f1, b_esc}) <= 1), 1);
`ifdef FME_CONTADOR_ERRO_EN
      chk("dut_a_erro", int'(a_erro), int'(m_err[0]));
      chk("dut_b_erro", int'(b_erro), int'(m_err[1]));
`endif
    end
  end

  // Hand-computed timing of a full default run started by enable in cycle 0.
  task automatic pin_full_run(input int c);
    chk("pin_escrita_fin", int'(a_esc),  int'(c == 8));
    chk("pin_fase1_fin",   int'(a_f1),   int'(c == 16));
    chk("pin_fase2p3_fin", int'(a_f2p3), int'(c == 25));
    chk("pin_fase3_fin",   int'(a_f3),   int'(c == 34));
    chk("pin_pos_fin",     int'(a_pos),  int'(c == 43));
    chk("pin_ocupado",     int'(a_ocup), int'(c >= 1 && c <= 43));
    chk("pin_b_fase3_fin", int'(b_f3),   int'(c == 26));
    chk("pin_b_pos_fin",   int'(b_pos),  int'(c == 35));
  endtask

  initial begin
    dur[0] = '{8, 8, 2, 7, 9, 2, 7};
    dur[1] = '{8, 8, 2, 7, 1, 2, 7};
    for (int m = 0; m < 2; m++) begin m_busy[m] = 1'b0; m_pos[m] = 0; m_err[m] = 1'b0; end
    enable = 1'b0; abortar = 1'b0; reset = 1'b1;
    cyc = 0;
    @(negedge clock);
    step(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    chk("reset_ocupado", int'(a_ocup), 0);
    chk("reset_contador", int'(a_cnt), 0);

    // Full default run.
    for (int c = 0; c < 46; c++) begin
      step(c == 0, 1'b0, 1'b0);
      cyc = c + 1;
      pin_full_run(cyc);
    end

    // Second enable during the run: timing unchanged, error flag set and held.
    for (int c = 0; c < 46; c++) begin
      step(c == 0 || c == 5, 1'b0, 1'b0);
      cyc = c + 1;
      pin_full_run(cyc);
    end
`ifdef FME_CONTADOR_ERRO_EN
    chk("pin_erro_held", int'(a_erro), 1);
`endif

    // Abort in FASE1 with contador=3.
    step(1'b1, 1'b0, 1'b0);
    cyc = 1;
    for (int c = 1; c < 12; c++) begin step(1'b0, 1'b0, 1'b0); cyc = c + 1; end
    chk("pin_abort_pre_cnt", int'(a_cnt), 3);
    chk("pin_abort_pre_f1", int'(dut_a_f1_state()), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("pin_abort_ocupado", int'(a_ocup), 0);
    chk("pin_abort_cnt", int'(a_cnt), 0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("pin_abort_no_fin", int'({a_pos, a_f3, a_f2p3, a_f1, a_esc}), 0);
    end

    // abortar and enable together while idle.
    step(1'b1, 1'b1, 1'b0);
    chk("pin_abort_enable_idle", int'(a_ocup), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("pin_abort_enable_idle2", int'(a_ocup), 0);

    // Reset during FASE3 at contador=4, then a fresh run.
    step(1'b1, 1'b0, 1'b0);
    cyc = 1;
    for (int c = 1; c < 30; c++) begin step(1'b0, 1'b0, 1'b0); cyc = c + 1; end
    chk("pin_rst_pre_cnt", int'(a_cnt), 4);
    step(1'b0, 1'b0, 1'b1);
    chk("pin_rst_all_zero", int'({a_ocup, a_pos, a_f3, a_f2p3, a_f1, a_esc, a_cnt}), 0);
    for (int c = 0; c < 46; c++) begin
      step(c == 0, 1'b0, 1'b0);
      cyc = c + 1;
      pin_full_run(cyc);
    end

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Phase-1 indication derived from the model's position at the pinned point.
  function automatic bit dut_a_f1_state();
    return (a_ocup && a_cnt == 4'd3 && m_pos[0] == 11);
  endfunction

endmodule

// File: doc/fme_contador_fases.md
FME_CONTADOR_FASES -- requirements
Module: fme_contador_fases

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 The parameters SHALL be as follows, one per line (name, default, meaning):
- N_ESCRITA, 8, cycles in integer-write phase.
- N_FASE1, 8, cycles in phase 1.
- N_FASE2P3, 7, cycles in phase 2 part 3.
- N_FASE3, 9, cycles in phase 3.
- N_POS, 7, cycles in post-interpolation part 3.
- CNT_WIDTH, 4, counter width.
REQ-003 The ports SHALL be as follows, one per line (name, direction, width, meaning):
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- enable, in, 1, start request; same signal that drives the controller enable.
- abortar, in, 1, synchronous abort to idle.
- escrita_finalizada, out, 1, last cycle of integer write.
- fase1_finalizada, out, 1, last cycle of phase 1.
- fase2p3_finalizada, out, 1, last cycle of phase 2 part 3.
- fase3_finalizada, out, 1, last cycle of phase 3.
- pos_interpolacao_finalizada, out, 1, last cycle of post-interpolation.
- contador, out, CNT_WIDTH, cycle index within current counted phase.
- ocupado, out, 1, high in every state except OCIOSO.

Function
REQ-004 The block SHALL run a tracking FSM in lockstep with the interpolation controller, with states OCIOSO, ESCRITA, FASE1, GAP2 (2 cycles), FASE2P3, FASE3, GAP_POS (2 cycles), POS3.
REQ-005 The FSM SHALL make these transitions:
- OCIOSO to ESCRITA on enable=1.
- ESCRITA to FASE1, FASE1 to GAP2, FASE2P3 to FASE3, FASE3 to GAP_POS and POS3 to OCIOSO, each on its finalizada signal.
- GAP2 to FASE2P3 and GAP_POS to POS3, each after exactly 2 cycles.
REQ-006 contador SHALL be 0 on the first cycle of each state, increment by 1 per cycle, and clear to 0 on every state change; it SHALL hold 0 in OCIOSO.
REQ-007 Each finalizada output SHALL be a decode of registered state only (no input path): it is 1 exactly when the FSM is in its phase and contador equals N-1 for that phase.
REQ-008 Each counted phase SHALL therefore last exactly N cycles; with default parameters the total from ESCRITA entry to OCIOSO return is 43 cycles.
REQ-009 At most one finalizada output SHALL be high in any cycle; all SHALL be 0 in OCIOSO, GAP2 and GAP_POS.
REQ-010 enable SHALL be ignored while ocupado=1.
REQ-011 abortar=1 SHALL force OCIOSO and contador=0 on the next edge.
REQ-012 When abortar and enable are high in the same cycle, abortar SHALL win and the FSM SHALL stay in OCIOSO.
REQ-013 Parameters SHALL satisfy 1 <= N <= 2^CNT_WIDTH; N=1 SHALL assert finalizada on the first cycle of the phase.
REQ-014 contador SHALL never wrap within a phase.

Reset
REQ-015 When reset=1 at a rising edge, the block SHALL set state to OCIOSO and contador to 0, which drives all finalizada outputs and ocupado to 0.
REQ-016 reset SHALL take priority over abortar and enable.
REQ-017 reset asserted mid-phase SHALL produce no finalizada pulse in the following cycle.

Configuration
REQ-018 When FME_CONTADOR_ERRO_EN is defined, the block SHALL add output erro_sequencia (1 bit), set sticky when enable=1 while ocupado=1, and cleared only by reset.
REQ-019 When FME_CONTADOR_ERRO_EN is undefined, erro_sequencia SHALL be absent and the function SHALL be otherwise identical.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Defaults, enable pulse at cycle 0 -> escrita_finalizada at cycle 8, fase1 at 16, fase2p3 at 25, fase3 at 34, pos at 43, ocupado=0 from cycle 44.
- Second enable pulse at cycle 5 of the run -> run timing unchanged; with macro, erro_sequencia=1 and held.
- abortar at cycle 12 (FASE1, contador=3) -> next cycle OCIOSO, contador=0, no further finalizada.
- abortar=1 and enable=1 together in OCIOSO -> stays OCIOSO, ocupado=0.
- reset during FASE3 at contador=4 -> next cycle all outputs 0; a new enable restarts the 43-cycle sequence.
- N_FASE3=1, CNT_WIDTH=4 -> fase3_finalizada high on the single FASE3 cycle; every cycle has at most one finalizada high.
